// File: rtl/plru_repl_ctrl.sv
// plru_repl_ctrl -- per-set tree-PLRU replacement controller for the L1D.
//
// Holds NWAY-1 PLRU bits per set. It applies hit updates from the lookup
// pipeline and serves victim-way requests from the refill path. Responses
// are registered and held until the consumer accepts them.
//
// Optional build macro: PLRU_INIT_EN
//   defined   : the state array has no reset. An INIT sweep clears one set per
//               cycle for NSET cycles after reset, so it can map onto SRAM.
//   undefined : the state array resets to 0, the FSM stays in RUN and
//               init_busy_o is tied low.
//
// Ports
//   clk, rst_n          clock and synchronous active-low reset
//   hit_vld_i/set/way   hit update strobe (dropped while INIT is running)
//   victim_req_*        victim request, valid/ready handshake
//   victim_resp_*       registered victim way, valid/ready handshake
//   init_busy_o         state array clear in progress
module plru_repl_ctrl #(
    parameter int NSET  = 64,
    parameter int NWAY  = 8,
    parameter int SET_W = $clog2(NSET),
    parameter int WAY_W = $clog2(NWAY),
    parameter int LRU_W = NWAY - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hit_vld_i,
    input  logic [SET_W-1:0] hit_set_i,
    input  logic [WAY_W-1:0] hit_way_i,
    input  logic             victim_req_vld_i,
    input  logic [SET_W-1:0] victim_req_set_i,
    output logic             victim_req_rdy_o,
    output logic             victim_resp_vld_o,
    output logic [WAY_W-1:0] victim_resp_way_o,
    input  logic             victim_resp_rdy_i,
    output logic             init_busy_o
);

    localparam logic [0:0] ST_RUN = 1'b1;

    // Heap-ordered tree: node k (1-based) is stored in bit k-1.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [LRU_W-1:0] lru);
        logic [WAY_W-1:0] v;
        int               node;
        logic             b;
        v    = '0;
        node = 1;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            b = 1'b0;
            for (int n = 0; n < LRU_W; n++)
                if (n == node - 1) b = lru[n];
            v[WAY_W-1-lvl] = b;
            node = 2 * node + (b ? 1 : 0);
        end
        return v;
    endfunction

    // Point every node on the path to way w away from w. Along the victim
    // path each node bit equals the victim's bit at that level. Touching the
    // victim therefore inverts that path, so this one function performs both
    // the hit update and the allocation update.
    function automatic logic [LRU_W-1:0] plru_touch(input logic [LRU_W-1:0] lru,
                                                    input logic [WAY_W-1:0] w);
        logic [LRU_W-1:0] r;
        int               node;
        logic             wb;
        r    = lru;
        node = 1;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            wb = w[WAY_W-1-lvl];
            for (int n = 0; n < LRU_W; n++)
                if (n == node - 1) r[n] = ~wb;
            node = 2 * node + (wb ? 1 : 0);
        end
        return r;
    endfunction

    logic [NSET-1:0][LRU_W-1:0] lru_q;
    logic [0:0]                 state;
    logic                       hit_en;
    logic                       acc;
    logic                       same_set;
    logic [LRU_W-1:0]           hit_next;
    logic [LRU_W-1:0]           req_cur;
    logic [LRU_W-1:0]           alloc_next;
    logic [WAY_W-1:0]           vic_way;
    logic                       resp_vld_q;
    logic [WAY_W-1:0]           resp_way_q;

`ifdef PLRU_INIT_EN
    localparam logic [0:0] ST_INIT = 1'b0;
    logic [SET_W-1:0] init_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + SET_W'(1);
            if (init_cnt == SET_W'(NSET - 1)) state <= ST_RUN;
        end
    end

    assign init_busy_o = (state == ST_INIT);
`else
    assign state       = ST_RUN;
    assign init_busy_o = 1'b0;
`endif

    assign hit_en           = hit_vld_i && (state == ST_RUN);
    assign victim_req_rdy_o = (state == ST_RUN) && (!resp_vld_q || victim_resp_rdy_i);
    assign acc              = victim_req_vld_i && victim_req_rdy_o;
    assign same_set         = hit_en && (hit_set_i == victim_req_set_i);

    // A same-set hit is folded in before the victim walk, so one write
    // carries both updates.
    assign hit_next   = plru_touch(lru_q[hit_set_i], hit_way_i);
    assign req_cur    = same_set ? hit_next : lru_q[victim_req_set_i];
    assign vic_way    = plru_victim(req_cur);
    assign alloc_next = plru_touch(req_cur, vic_way);

`ifdef PLRU_INIT_EN
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            lru_q[init_cnt] <= '0;
        end else begin
            if (hit_en) lru_q[hit_set_i] <= hit_next;
            // Later write wins on a same-set collision; alloc_next already has the hit.
            if (acc) lru_q[victim_req_set_i] <= alloc_next;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lru_q <= '0;
        end else begin
            if (hit_en) lru_q[hit_set_i] <= hit_next;
            if (acc) lru_q[victim_req_set_i] <= alloc_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_vld_q <= 1'b0;
            resp_way_q <= '0;
        end else if (acc) begin
            resp_vld_q <= 1'b1;
            resp_way_q <= vic_way;
        end else if (victim_resp_rdy_i) begin
            resp_vld_q <= 1'b0;
        end
    end

    assign victim_resp_vld_o = resp_vld_q;
    assign victim_resp_way_o = resp_way_q;

endmodule

// File: tb/tb_plru_repl_ctrl.sv
// Directed bench for plru_repl_ctrl (NSET=64, NWAY=8). Expected PLRU states
// and victim ways are worked out by hand from the tree rules.
module tb_plru_repl_ctrl;

    localparam int NSET  = 64;
    localparam int NWAY  = 8;
    localparam int SET_W = 6;
    localparam int WAY_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             hit_vld_i;
    logic [SET_W-1:0] hit_set_i;
    logic [WAY_W-1:0] hit_way_i;
    logic             victim_req_vld_i;
    logic [SET_W-1:0] victim_req_set_i;
    logic             victim_req_rdy_o;
    logic             victim_resp_vld_o;
    logic [WAY_W-1:0] victim_resp_way_o;
    logic             victim_resp_rdy_i;
    logic             init_busy_o;

    int checks = 0;
    int errors = 0;

    plru_repl_ctrl #(.NSET(NSET), .NWAY(NWAY)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .hit_vld_i         (hit_vld_i),
        .hit_set_i         (hit_set_i),
        .hit_way_i         (hit_way_i),
        .victim_req_vld_i  (victim_req_vld_i),
        .victim_req_set_i  (victim_req_set_i),
        .victim_req_rdy_o  (victim_req_rdy_o),
        .victim_resp_vld_o (victim_resp_vld_o),
        .victim_resp_way_o (victim_resp_way_o),
        .victim_resp_rdy_i (victim_resp_rdy_i),
        .init_busy_o       (init_busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lru(input int s);
        return 32'(dut.lru_q[s]);
    endfunction

    initial begin
        rst_n             = 1'b0;
        hit_vld_i         = 1'b0;
        hit_set_i         = '0;
        hit_way_i         = '0;
        victim_req_vld_i  = 1'b0;
        victim_req_set_i  = '0;
        victim_resp_rdy_i = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_resp_vld", 32'(victim_resp_vld_o), 32'd0);
        chk("rst_resp_way", 32'(victim_resp_way_o), 32'd0);
`ifdef PLRU_INIT_EN
        chk("rst_rdy", 32'(victim_req_rdy_o), 32'd0);
        chk("rst_busy", 32'(init_busy_o), 32'd1);
        rst_n = 1'b1;
        // INIT sweep: busy for exactly NSET cycles; a hit on set 1 mid-sweep is dropped
        for (int i = 0; i < NSET; i++) begin
            chk("init_busy", 32'(init_busy_o), 32'd1);
            chk("init_rdy", 32'(victim_req_rdy_o), 32'd0);
            if (i == 5) begin
                hit_vld_i = 1'b1;
                hit_set_i = 6'd1;
                hit_way_i = 3'd4;
            end
            if (i == 6) hit_vld_i = 1'b0;
            step();
        end
        chk("init_done_rdy", 32'(victim_req_rdy_o), 32'd1);
        chk("init_done_busy", 32'(init_busy_o), 32'd0);
        chk("init_hit_dropped", lru(1), 32'h00);
`else
        chk("rst_rdy", 32'(victim_req_rdy_o), 32'd1);
        chk("rst_busy", 32'(init_busy_o), 32'd0);
        rst_n = 1'b1;
        step();
        chk("run_rdy", 32'(victim_req_rdy_o), 32'd1);
`endif

        // Back-to-back victims on set 5, one response per cycle
        victim_req_vld_i = 1'b1;
        victim_req_set_i = 6'd5;
        step();
        chk("b2b1_vld", 32'(victim_resp_vld_o), 32'd1);
        chk("b2b1_way", 32'(victim_resp_way_o), 32'd0);
        chk("b2b1_lru", lru(5), 32'h0B);
        chk("b2b1_rdy", 32'(victim_req_rdy_o), 32'd1);
        step();
        chk("b2b2_vld", 32'(victim_resp_vld_o), 32'd1);
        chk("b2b2_way", 32'(victim_resp_way_o), 32'd4);
        chk("b2b2_lru", lru(5), 32'h2E);
        victim_req_vld_i = 1'b0;
        step();
        chk("b2b_drain", 32'(victim_resp_vld_o), 32'd0);

        // Hit set 3 way 4, then victim on set 3 the next cycle
        hit_vld_i = 1'b1;
        hit_set_i = 6'd3;
        hit_way_i = 3'd4;
        step();
        hit_vld_i = 1'b0;
        chk("hit_lru", lru(3), 32'h24);
        victim_req_vld_i = 1'b1;
        victim_req_set_i = 6'd3;
        step();
        victim_req_vld_i = 1'b0;
        chk("hitvic_way", 32'(victim_resp_way_o), 32'd0);
        chk("hitvic_lru", lru(3), 32'h2F);
        step();

        // Same-cycle hit (way 0) and victim request on set 7
        hit_vld_i        = 1'b1;
        hit_set_i        = 6'd7;
        hit_way_i        = 3'd0;
        victim_req_vld_i = 1'b1;
        victim_req_set_i = 6'd7;
        step();
        hit_vld_i        = 1'b0;
        victim_req_vld_i = 1'b0;
        chk("same_way", 32'(victim_resp_way_o), 32'd4);
        chk("same_lru", lru(7), 32'h2E);
        step();

        // Same-cycle hit on set 10 (way 3) and victim on set 11
        hit_vld_i        = 1'b1;
        hit_set_i        = 6'd10;
        hit_way_i        = 3'd3;
        victim_req_vld_i = 1'b1;
        victim_req_set_i = 6'd11;
        step();
        hit_vld_i        = 1'b0;
        victim_req_vld_i = 1'b0;
        chk("diff_hit_lru", lru(10), 32'h01);
        chk("diff_vic_lru", lru(11), 32'h0B);
        chk("diff_vic_way", 32'(victim_resp_way_o), 32'd0);
        step();

        // Backpressure: first response (set 20) stalls, second (set 5) waits
        victim_resp_rdy_i = 1'b0;
        victim_req_vld_i  = 1'b1;
        victim_req_set_i  = 6'd20;
        step();
        victim_req_set_i = 6'd5;
        for (int i = 0; i < 3; i++) begin
            chk("bp_vld", 32'(victim_resp_vld_o), 32'd1);
            chk("bp_way", 32'(victim_resp_way_o), 32'd0);
            chk("bp_rdy", 32'(victim_req_rdy_o), 32'd0);
            chk("bp_lru5", lru(5), 32'h2E);
            step();
        end
        chk("bp_lru20", lru(20), 32'h0B);
        victim_resp_rdy_i = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(victim_req_rdy_o), 32'd1);
        step();
        victim_req_vld_i = 1'b0;
        chk("bp2_vld", 32'(victim_resp_vld_o), 32'd1);
        chk("bp2_way", 32'(victim_resp_way_o), 32'd2);
        chk("bp2_lru", lru(5), 32'h3D);
        step();

        // Reset while a response is pending
        victim_resp_rdy_i = 1'b0;
        victim_req_vld_i  = 1'b1;
        victim_req_set_i  = 6'd30;
        step();
        victim_req_vld_i = 1'b0;
        chk("mid_pending", 32'(victim_resp_vld_o), 32'd1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_vld", 32'(victim_resp_vld_o), 32'd0);
        chk("mid_rst_way", 32'(victim_resp_way_o), 32'd0);
`ifdef PLRU_INIT_EN
        chk("mid_rst_busy", 32'(init_busy_o), 32'd1);
        chk("mid_rst_rdy", 32'(victim_req_rdy_o), 32'd0);
        chk("mid_rst_cnt", 32'(dut.init_cnt), 32'd0);
        rst_n = 1'b1;
        step();
        chk("mid_init_cnt", 32'(dut.init_cnt), 32'd1);
        repeat (NSET - 1) step();
        chk("mid_init_rdy", 32'(victim_req_rdy_o), 32'd1);
        chk("mid_init_busy", 32'(init_busy_o), 32'd0);
        chk("mid_init_lru5", lru(5), 32'h00);
`else
        chk("mid_rst_lru5", lru(5), 32'h00);
        chk("mid_rst_lru3", lru(3), 32'h00);
        rst_n = 1'b1;
        step();
        chk("mid_rst_rdy", 32'(victim_req_rdy_o), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
